// File: rtl/edge_seq_ctrl.sv
// edge_seq_ctrl: sequencer for the gaussian -> sobel -> non-max edge pipeline.
// Tracks the 5-lane frame-buffer load, raster-scans the 3x3 window center,
// delays window-valid through the datapath latency into readable/out_idx and
// pulses done after the final result.
// Build option: define EDGE_SEQ_BORDER_EN to scan the full frame (including
// border pixels) and expose the pad_mask output.
module edge_seq_ctrl #(
  parameter int IMG_W    = 20,
  parameter int IMG_H    = 20,
  parameter int LANES    = 5,
  parameter int PIPE_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       load_end,
  input  logic       stall,
  output logic       wr_en,
  output logic [2:0] wr_strip,
  output logic [4:0] wr_col,
  output logic       win_valid,
  output logic [4:0] win_row,
  output logic [4:0] win_col,
  output logic       readable,
  output logic [8:0] out_idx,
  output logic       busy,
  output logic       done
`ifdef EDGE_SEQ_BORDER_EN
  ,
  output logic [3:0] pad_mask
`endif
);

  localparam int         STRIPS      = IMG_H / LANES;
  localparam logic [2:0] STRIP_LAST  = 3'(STRIPS - 1);
  localparam logic [4:0] WR_COL_LAST = 5'(IMG_W - 1);
`ifdef EDGE_SEQ_BORDER_EN
  localparam logic [4:0] SCAN_ROW_FIRST = 5'd0;
  localparam logic [4:0] SCAN_COL_FIRST = 5'd0;
  localparam logic [4:0] SCAN_ROW_LAST  = 5'(IMG_H - 1);
  localparam logic [4:0] SCAN_COL_LAST  = 5'(IMG_W - 1);
`else
  localparam logic [4:0] SCAN_ROW_FIRST = 5'd1;
  localparam logic [4:0] SCAN_COL_FIRST = 5'd1;
  localparam logic [4:0] SCAN_ROW_LAST  = 5'(IMG_H - 2);
  localparam logic [4:0] SCAN_COL_LAST  = 5'(IMG_W - 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [2:0]          r_strip;
  logic [4:0]          r_col;
  logic [4:0]          r_wrow;
  logic [4:0]          r_wcol;
  logic                r_done;
  logic [PIPE_LAT-1:0] r_vld_pipe;
  logic [8:0]          r_out_idx;

  logic                w_wr_en;
  logic                w_load_last;
  logic                w_scan_last;
  logic                w_win_valid;
  logic                w_readable;
  logic [PIPE_LAT-1:0] w_vld_next;

  // The first beat is accepted straight from IDLE, so the write strobe covers both states.
  assign w_wr_en     = in_valid && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_load_last = load_end || (r_strip == STRIP_LAST && r_col == WR_COL_LAST);
  assign w_scan_last = (r_wrow == SCAN_ROW_LAST) && (r_wcol == SCAN_COL_LAST);
  assign w_win_valid = (r_state == S_SCAN) && !stall;
  // Stall freezes the whole valid pipeline, so a frozen tap never fires readable.
  assign w_vld_next  = stall ? r_vld_pipe : ((r_vld_pipe << 1) | PIPE_LAT'(w_win_valid));
  assign w_readable  = r_vld_pipe[PIPE_LAT-1] && !stall;

  assign wr_en     = w_wr_en;
  assign wr_strip  = r_strip;
  assign wr_col    = r_col;
  assign win_valid = w_win_valid;
  assign win_row   = r_wrow;
  assign win_col   = r_wcol;
  assign readable  = w_readable;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = r_done;

  // Frame FSM: load counters, scan coordinates and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_strip <= '0;
      r_col   <= '0;
      r_wrow  <= '0;
      r_wcol  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_wr_en) begin
            if (w_load_last) begin
              r_state <= S_SCAN;
              r_strip <= '0;
              r_col   <= '0;
              r_wrow  <= SCAN_ROW_FIRST;
              r_wcol  <= SCAN_COL_FIRST;
            end else begin
              r_state <= S_LOAD;
              if (r_col == WR_COL_LAST) begin
                r_col   <= '0;
                r_strip <= r_strip + 3'd1;
              end else begin
                r_col <= r_col + 5'd1;
              end
            end
          end
        end
        S_SCAN: begin
          if (!stall) begin
            if (w_scan_last) begin
              r_state <= S_DRAIN;
            end else if (r_wcol == SCAN_COL_LAST) begin
              r_wcol <= SCAN_COL_FIRST;
              r_wrow <= r_wrow + 5'd1;
            end else begin
              r_wcol <= r_wcol + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          // Leave as the last result is being delivered so done lands one cycle later.
          if (w_vld_next == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_wrow  <= '0;
          r_wcol  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid pipeline tracking datapath latency, and the output raster index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_out_idx  <= '0;
    end else begin
      r_vld_pipe <= w_vld_next;
      if (r_state == S_DONE) begin
        r_out_idx <= '0;
      end else if (w_readable) begin
        r_out_idx <= r_out_idx + 9'd1;
      end
    end
  end

`ifdef EDGE_SEQ_BORDER_EN
  logic [3:0] w_pad;
  logic [3:0] r_pad_pipe [PIPE_LAT];

  // Edge flags: top, bottom, left, right of the window lie outside the frame.
  assign w_pad = {r_wrow == 5'd0, r_wrow == 5'(IMG_H - 1),
                  r_wcol == 5'd0, r_wcol == 5'(IMG_W - 1)};

  // Pad flags ride alongside the valid pipeline; they are only meaningful with readable.
  always_ff @(posedge clk) begin
    if (!stall) begin
      r_pad_pipe[0] <= w_pad;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pad_pipe[i] <= r_pad_pipe[i-1];
      end
    end
  end

  assign pad_mask = w_readable ? r_pad_pipe[PIPE_LAT-1] : 4'b0000;
`endif

endmodule

// File: tb/tb_edge_seq_ctrl.sv
// tb_edge_seq_ctrl: directed vector table for load/scan start-up plus
// hand-written multi-cycle sequences for full frames, stalls and reset.
module tb_edge_seq_ctrl;

  localparam int PIPE_LAT = 4;
`ifdef EDGE_SEQ_BORDER_EN
  localparam int B     = 1;
  localparam int N_OUT = 400;
`else
  localparam int B     = 0;
  localparam int N_OUT = 324;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       load_end;
  logic       stall;
  logic       wr_en;
  logic [2:0] wr_strip;
  logic [4:0] wr_col;
  logic       win_valid;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic       readable;
  logic [8:0] out_idx;
  logic       busy;
  logic       done;
`ifdef EDGE_SEQ_BORDER_EN
  logic [3:0] pad_mask;
`endif

  edge_seq_ctrl #(.IMG_W(20), .IMG_H(20), .LANES(5), .PIPE_LAT(PIPE_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .load_end (load_end),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_strip (wr_strip),
    .wr_col   (wr_col),
    .win_valid(win_valid),
    .win_row  (win_row),
    .win_col  (win_col),
    .readable (readable),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
`ifdef EDGE_SEQ_BORDER_EN
    ,
    .pad_mask (pad_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit iv; bit le; bit st;
    bit e_wr; int e_strip; int e_wcol;
    bit e_win; int e_row; int e_col;
    bit e_rd; int e_idx;
    bit e_busy; bit e_done;
  } vec_t;

  vec_t tbl [17];

  function automatic int sc(input int n);
    return n - B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: inputs change 1 time unit after the edge, outputs sampled mid-cycle.
  task automatic cyc(input bit iv, input bit le, input bit st);
    @(posedge clk);
    #1;
    in_valid = iv;
    load_end = le;
    stall    = st;
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0; load_end = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"},     wr_en,     0);
    chk({tag, ".wr_strip"},  wr_strip,  0);
    chk({tag, ".wr_col"},    wr_col,    0);
    chk({tag, ".win_valid"}, win_valid, 0);
    chk({tag, ".win_row"},   win_row,   0);
    chk({tag, ".win_col"},   win_col,   0);
    chk({tag, ".readable"},  readable,  0);
    chk({tag, ".out_idx"},   out_idx,   0);
    chk({tag, ".busy"},      busy,      0);
    chk({tag, ".done"},      done,      0);
  endtask

  // Drive a load; le_beat < 0 means no load_end. Gapped drops every third cycle.
  task automatic load_frame(input string tag, input int nbeats, input int le_beat,
                            input bit gapped, input int exp_strip, input int exp_col);
    int beat = 0;
    int k = 0;
    int wr_bad = 0;
    bit iv;
    logic [2:0] ls = '0;
    logic [4:0] lc = '0;
    while (beat < nbeats && k < 500) begin
      iv = gapped ? (k % 3 != 2) : 1'b1;
      cyc(iv, iv && (beat == le_beat), 1'b0);
      if (wr_en !== iv) wr_bad++;
      if (iv) begin
        ls = wr_strip;
        lc = wr_col;
        beat++;
      end
      k++;
    end
    chk({tag, ".wr_en_follows_valid"}, wr_bad, 0);
    chk({tag, ".last_strip"}, ls, exp_strip);
    chk({tag, ".last_col"},   lc, exp_col);
  endtask

  // Run from the first SCAN cycle until done; cycle 0 is the cycle after the last beat.
  task automatic run_scan(input string tag, input bit do_stall,
                          input int exp_last_win, input int exp_done);
    int n_win = 0, n_read = 0, n_done = 0;
    int first_rd = -1, last_win_c = -1, done_c = -1;
    int idx_bad = 0, stall_bad = 0, hold_bad = 0, wr_bad = 0;
    int stall_left = 0;
    int drain_busy = -1, done_busy = -1;
    bit stalled = 1'b0;
    bit st;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      st = 1'b0;
      if (do_stall && !stalled && n_win > 0 && win_row == 5'd5 && win_col == 5'd9) begin
        stall_left = 7;
        stalled = 1'b1;
      end
      if (stall_left > 0) begin
        st = 1'b1;
        stall_left--;
      end
      if (do_stall && n_win == N_OUT && c == last_win_c + 2) st = 1'b1;
      in_valid = (n_win < N_OUT) && (c % 5 == 0);
      load_end = in_valid;
      stall    = st;
      #3;
      if (in_valid && wr_en) wr_bad++;
      if (win_valid) begin
        if (n_win == 0) begin
          chk({tag, ".first_row"}, win_row, sc(1));
          chk({tag, ".first_col"}, win_col, sc(1));
          chk({tag, ".first_win_cycle"}, c, 0);
        end
        n_win++;
        last_win_c = c;
      end
      if (st && (win_valid || readable)) stall_bad++;
      if (st && n_win < N_OUT && (win_row != 5'd5 || win_col != 5'd9)) hold_bad++;
      if (n_win == N_OUT && c == last_win_c + 1) drain_busy = busy;
      if (readable) begin
        if (n_read == 0) first_rd = c;
        if (out_idx != 9'(n_read)) idx_bad++;
`ifdef EDGE_SEQ_BORDER_EN
        if (n_read == 0)   chk({tag, ".pad0"},   pad_mask, 4'b1010);
        if (n_read == 21)  chk({tag, ".pad21"},  pad_mask, 4'b0000);
        if (n_read == 399) chk({tag, ".pad399"}, pad_mask, 4'b0101);
`endif
        n_read++;
      end
      if (done) begin
        n_done++;
        done_c = c;
        done_busy = busy;
      end
      if (n_done > 0 && c >= done_c + 3) break;
    end
    in_valid = 1'b0;
    load_end = 1'b0;
    stall    = 1'b0;
    chk({tag, ".win_count"},       n_win, N_OUT);
    chk({tag, ".last_win_cycle"},  last_win_c, exp_last_win);
    chk({tag, ".read_count"},      n_read, N_OUT);
    chk({tag, ".first_read"},      first_rd, PIPE_LAT);
    chk({tag, ".idx_seq_errors"},  idx_bad, 0);
    chk({tag, ".done_pulses"},     n_done, 1);
    chk({tag, ".done_cycle"},      done_c, exp_done);
    chk({tag, ".busy_in_drain"},   drain_busy, 1);
    chk({tag, ".busy_in_done"},    done_busy, 0);
    chk({tag, ".scan_wr_en"},      wr_bad, 0);
    if (do_stall) begin
      chk({tag, ".stall_outputs"}, stall_bad, 0);
      chk({tag, ".stall_hold"},    hold_bad, 0);
    end
  endtask

  initial begin
    int found;
    int bad;
    reset = 1'b1; in_valid = 1'b0; load_end = 1'b0; stall = 1'b0;

    //            iv le st | wr strip wcol | win row    col    | rd idx | busy done
    tbl[0]  = '{0, 0, 0,  0, 0, 0,  0, 0,     0,     0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0,  1, 0, 0,  0, 0,     0,     0, 0,  0, 0};
    tbl[2]  = '{1, 0, 0,  1, 0, 1,  0, 0,     0,     0, 0,  1, 0};
    tbl[3]  = '{0, 0, 0,  0, 0, 2,  0, 0,     0,     0, 0,  1, 0};
    tbl[4]  = '{1, 0, 0,  1, 0, 2,  0, 0,     0,     0, 0,  1, 0};
    tbl[5]  = '{0, 1, 0,  0, 0, 3,  0, 0,     0,     0, 0,  1, 0};
    tbl[6]  = '{1, 0, 0,  1, 0, 3,  0, 0,     0,     0, 0,  1, 0};
    tbl[7]  = '{1, 1, 0,  1, 0, 4,  0, 0,     0,     0, 0,  1, 0};
    tbl[8]  = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(1), 0, 0,  1, 0};
    tbl[9]  = '{1, 0, 0,  0, 0, 0,  1, sc(1), sc(2), 0, 0,  1, 0};
    tbl[10] = '{0, 0, 1,  0, 0, 0,  0, sc(1), sc(3), 0, 0,  1, 0};
    tbl[11] = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(3), 0, 0,  1, 0};
    tbl[12] = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(4), 0, 0,  1, 0};
    tbl[13] = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(5), 1, 0,  1, 0};
    tbl[14] = '{0, 0, 1,  0, 0, 0,  0, sc(1), sc(6), 0, 1,  1, 0};
    tbl[15] = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(6), 1, 1,  1, 0};
    tbl[16] = '{0, 0, 0,  0, 0, 0,  1, sc(1), sc(7), 1, 2,  1, 0};

    @(posedge clk);
    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].iv, tbl[i].le, tbl[i].st);
      chk($sformatf("v%0d.wr_en", i),     wr_en,     tbl[i].e_wr);
      chk($sformatf("v%0d.wr_strip", i),  wr_strip,  tbl[i].e_strip);
      chk($sformatf("v%0d.wr_col", i),    wr_col,    tbl[i].e_wcol);
      chk($sformatf("v%0d.win_valid", i), win_valid, tbl[i].e_win);
      chk($sformatf("v%0d.win_row", i),   win_row,   tbl[i].e_row);
      chk($sformatf("v%0d.win_col", i),   win_col,   tbl[i].e_col);
      chk($sformatf("v%0d.readable", i),  readable,  tbl[i].e_rd);
      chk($sformatf("v%0d.out_idx", i),   out_idx,   tbl[i].e_idx);
      chk($sformatf("v%0d.busy", i),      busy,      tbl[i].e_busy);
      chk($sformatf("v%0d.done", i),      done,      tbl[i].e_done);
    end

    // Nominal frame: 80 back-to-back beats, load_end on beat 79.
    do_reset();
    load_frame("nominal", 80, 79, 1'b0, 3, 19);
    run_scan("nominal", 1'b0, N_OUT - 1, N_OUT + PIPE_LAT);

    // Gapped load without load_end; the beat count alone ends LOAD. No reset: next frame accepted.
    load_frame("gapped", 80, -1, 1'b1, 3, 19);
    run_scan("gapped", 1'b0, N_OUT - 1, N_OUT + PIPE_LAT);

    // Early load_end on beat 39.
    load_frame("early", 40, 39, 1'b0, 1, 19);
    run_scan("early", 1'b0, N_OUT - 1, N_OUT + PIPE_LAT);

    // 7-cycle stall at (5,9) plus one stall cycle in DRAIN.
    load_frame("stall", 80, 79, 1'b0, 3, 19);
    run_scan("stall", 1'b1, N_OUT - 1 + 7, N_OUT + PIPE_LAT + 8);

    // Reset mid-SCAN at (10,3).
    load_frame("midrst", 80, 79, 1'b0, 3, 19);
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0; load_end = 1'b0; stall = 1'b0;
      if (win_row == 5'd10 && win_col == 5'd3) begin
        reset = 1'b1;
        found = 1;
      end
      #3;
      if (found != 0) break;
    end
    chk("midrst.reached_10_3", found, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    chk_all_zero("midrst");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (readable || done || busy || win_valid) bad++;
    end
    chk("midrst.quiet_after_reset", bad, 0);
    load_frame("after_rst", 80, 79, 1'b0, 3, 19);
    run_scan("after_rst", 1'b0, N_OUT - 1, N_OUT + PIPE_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
